operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader.sv | 143 ++++++++++++++
 tb/tb_operand_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
// operand_loader: debounces two raw push buttons and, on each accepted press,
// captures the slider value n0 into the matching operand register (n1 / n2).
// Each button has its own two-flop synchronizer, four-state debounce FSM and
// saturating-free debounce counter. All outputs are registered.
module operand_loader #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] n0,
    input  logic       p1,
    input  logic       p2,
    output logic [3:0] n1,
    output logic [3:0] n2,
    output logic       ld1,
    output logic       ld2,
    output logic       both_valid
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    // Index 0 tracks button p1 (operand 1), index 1 tracks button p2 (operand 2).
    logic [1:0]    s1_r;
    logic [1:0]    s2_r;
    db_state_e     state_r [2];
    logic [CW-1:0] cnt_r   [2];
    logic [1:0]    fire_s;
    logic          got1_r;
    logic          got2_r;

    // Two-flop synchronizers for the raw asynchronous buttons.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_r <= 2'b00;
            s2_r <= 2'b00;
        end else begin
            s1_r <= {p2, p1};
            s2_r <= s1_r;
        end
    end

    // A press is accepted on the edge where PRESS_WAIT has seen a full stable window.
    always_comb begin
        fire_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if ((state_r[i] == PRESS_WAIT) && s2_r[i] && (cnt_r[i] == CNT_MAX)) begin
                fire_s[i] = 1'b1;
            end else begin
                fire_s[i] = 1'b0;
            end
        end
    end

    // Per-button debounce FSMs; the counter is cleared on entry to each wait state
    // and stops at CNT_MAX because the state leaves before it could increment further.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                state_r[i] <= RELEASED;
                cnt_r[i]   <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (state_r[i])
                    RELEASED: begin
                        if (s2_r[i]) begin
                            state_r[i] <= PRESS_WAIT;
                            cnt_r[i]   <= CNT_ZERO;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s2_r[i]) begin
                            state_r[i] <= RELEASED;
                        end else if (cnt_r[i] == CNT_MAX) begin
                            state_r[i] <= PRESSED;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!s2_r[i]) begin
                            state_r[i] <= RELEASE_WAIT;
                            cnt_r[i]   <= CNT_ZERO;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (s2_r[i]) begin
                            state_r[i] <= PRESSED;
                        end else if (cnt_r[i] == CNT_MAX) begin
                            state_r[i] <= RELEASED;
                        end else begin
                            cnt_r[i] <= cnt_r[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r[i] <= RELEASED;
                        cnt_r[i]   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Operand capture, one-cycle load strobes and the sticky both-loaded flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            n1         <= 4'h0;
            n2         <= 4'h0;
            ld1        <= 1'b0;
            ld2        <= 1'b0;
            got1_r     <= 1'b0;
            got2_r     <= 1'b0;
            both_valid <= 1'b0;
        end else begin
            if (fire_s[0]) begin
                n1 <= n0;
            end else begin
                n1 <= n1;
            end
            if (fire_s[1]) begin
                n2 <= n0;
            end else begin
                n2 <= n2;
            end
            ld1        <= fire_s[0];
            ld2        <= fire_s[1];
            got1_r     <= got1_r | ld1;
            got2_r     <= got2_r | ld2;
            both_valid <= both_valid | ((got1_r | ld1) & (got2_r | ld2));
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DB_CYCLES=4 (load 7 ticks after the
// button is driven, since the first following edge is sampling edge 0).
module tb_operand_loader;

    logic       clock;
    logic       reset_n;
    logic [3:0] n0;
    logic       p1;
    logic       p2;
    logic [3:0] n1;
    logic [3:0] n2;
    logic       ld1;
    logic       ld2;
    logic       both_valid;

    int checks;
    int errors;
    int ld1_cnt;
    int ld2_cnt;

    operand_loader #(.DB_CYCLES(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .n0         (n0),
        .p1         (p1),
        .p2         (p2),
        .n1         (n1),
        .n2         (n2),
        .ld1        (ld1),
        .ld2        (ld2),
        .both_valid (both_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance n cycles, accumulating observed load pulses.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ld1_cnt += int'(ld1);
            ld2_cnt += int'(ld2);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ld1_cnt = 0;
        ld2_cnt = 0;
        reset_n = 1'b0;
        n0      = 4'h0;
        p1      = 1'b0;
        p2      = 1'b0;
        run(3);
        check("rst_n1", {4'h0, n1}, 8'h00);
        check("rst_n2", {4'h0, n2}, 8'h00);
        check("rst_ld1", {7'h0, ld1}, 8'h00);
        check("rst_ld2", {7'h0, ld2}, 8'h00);
        check("rst_bv", {7'h0, both_valid}, 8'h00);
        reset_n = 1'b1;
        run(2);

        // Basic load of operand 1: load at edge 6.
        n0 = 4'hA;
        p1 = 1'b1;
        ld1_cnt = 0;
        run(6);
        check("t1_noload_early", 8'(ld1_cnt), 8'd0);
        check("t1_n1_early", {4'h0, n1}, 8'h00);
        tick();
        check("t1_n1", {4'h0, n1}, 8'h0A);
        check("t1_ld1", {7'h0, ld1}, 8'h01);
        tick();
        check("t1_ld1_off", {7'h0, ld1}, 8'h00);
        check("t1_n2", {4'h0, n2}, 8'h00);
        check("t1_bv", {7'h0, both_valid}, 8'h00);
        p1 = 1'b0;
        run(12);

        // Short glitch on p2 must not load.
        ld2_cnt = 0;
        p2 = 1'b1;
        run(3);
        p2 = 1'b0;
        run(12);
        check("t2_glitch_ld2", 8'(ld2_cnt), 8'd0);
        check("t2_glitch_n2", {4'h0, n2}, 8'h00);
        n0 = 4'h5;
        p2 = 1'b1;
        run(6);
        check("t2_noload_early", 8'(ld2_cnt), 8'd0);
        tick();
        check("t2_n2", {4'h0, n2}, 8'h05);
        check("t2_ld2", {7'h0, ld2}, 8'h01);
        check("t2_bv_pre", {7'h0, both_valid}, 8'h00);
        tick();
        check("t2_bv", {7'h0, both_valid}, 8'h01);
        p2 = 1'b0;
        run(12);

        // Long hold with changing n0: a single load capturing the value at the load edge.
        ld1_cnt = 0;
        n0 = 4'h3;
        p1 = 1'b1;
        run(3);
        n0 = 4'hC;
        run(17);
        n0 = 4'h9;
        run(30);
        check("t3_one_ld1", 8'(ld1_cnt), 8'd1);
        check("t3_n1", {4'h0, n1}, 8'h0C);
        p1 = 1'b0;
        run(12);

        // Simultaneous presses load together.
        n0 = 4'h7;
        p1 = 1'b1;
        p2 = 1'b1;
        run(6);
        tick();
        check("t4_ld1", {7'h0, ld1}, 8'h01);
        check("t4_ld2", {7'h0, ld2}, 8'h01);
        check("t4_n1", {4'h0, n1}, 8'h07);
        check("t4_n2", {4'h0, n2}, 8'h07);
        p2 = 1'b0;
        p1 = 1'b0;
        run(12);

        // Reset mid-debounce (PRESS_WAIT count 2), then reload with button still held.
        n0 = 4'hE;
        p1 = 1'b1;
        run(5);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_n1", {4'h0, n1}, 8'h00);
        check("t5_async_n2", {4'h0, n2}, 8'h00);
        check("t5_async_bv", {7'h0, both_valid}, 8'h00);
        tick();
        reset_n = 1'b1;
        ld1_cnt = 0;
        run(6);
        check("t5_noload_early", 8'(ld1_cnt), 8'd0);
        tick();
        check("t5_n1", {4'h0, n1}, 8'h0E);
        check("t5_ld1", {7'h0, ld1}, 8'h01);
        p1 = 1'b0;
        run(12);

        // Bounce 1,0,1,0 then hold: one reload after the stable window.
        n0 = 4'hB;
        ld1_cnt = 0;
        p1 = 1'b1;
        run(1);
        p1 = 1'b0;
        run(1);
        p1 = 1'b1;
        run(1);
        p1 = 1'b0;
        run(1);
        p1 = 1'b1;
        run(6);
        check("t6_noload_bounce", 8'(ld1_cnt), 8'd0);
        check("t6_n1_hold", {4'h0, n1}, 8'h0E);
        run(1);
        check("t6_n1", {4'h0, n1}, 8'h0B);
        run(10);
        check("t6_one_ld1", 8'(ld1_cnt), 8'd1);
        p1 = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
